// File: rtl/input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// input_conditioner_pkg
// Shared constants and helpers for the input conditioner front end.
//   SYNC_STAGES_DEF     : default synchroniser depth per raw input
//   DEBOUNCE_CYCLES_DEF : default number of consecutive differing cycles
//                         needed before a debounced value flips
//   CNT_W_DEF           : default width of the strobe event counter
//   cnt_width()         : width of a debounce counter able to reach
//                         DEBOUNCE_CYCLES-1 with one bit of headroom
// -----------------------------------------------------------------------------
package input_conditioner_pkg;

    localparam int SYNC_STAGES_DEF     = 32'sd2;
    localparam int DEBOUNCE_CYCLES_DEF = 32'sd4;
    localparam int CNT_W_DEF           = 32'sd8;

    // Debounce counter width: clog2(cycles) + 1.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 32'sd1;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_ch.sv
// -----------------------------------------------------------------------------
// debounce_ch
// One conditioning channel: an N-flop synchroniser followed by a debouncer.
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-low reset
//   raw   in  raw input, asynchronous to clk
//   level out debounced (stable) level, a register
//   flip  out combinational: high in the cycle whose closing edge toggles
//             level (level ^ flip is the next value of level)
// -----------------------------------------------------------------------------
module debounce_ch
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic flip
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'sd1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   synced_s;
    logic                   stable_r;
    logic [CW-1:0]          cnt_r;
    logic                   stable_nxt_s;
    logic [CW-1:0]          cnt_nxt_s;
    logic                   flip_s;

    assign synced_s = sync_r[SYNC_STAGES-1];

    // Synchroniser shift chain; the oldest stage is the synced value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    // Debounce decision: any agreement with stable wipes progress, so a
    // short glitch never accumulates across separate deviations.
    always_comb begin
        stable_nxt_s = stable_r;
        cnt_nxt_s    = cnt_r;
        flip_s       = 1'b0;
        if (synced_s == stable_r) begin
            cnt_nxt_s = {CW{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            stable_nxt_s = synced_s;
            cnt_nxt_s    = {CW{1'b0}};
            flip_s       = 1'b1;
        end else begin
            cnt_nxt_s = cnt_r + CW'(1'b1);
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
        end else begin
            stable_r <= stable_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    assign level = stable_r;
    assign flip  = flip_s;

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Front end for the 3-bit FSM: synchronises and debounces two raw inputs,
// presents a clean level d and a one-cycle step strobe s, and counts strobes.
// Ports:
//   clk     in  system clock, rising edge
//   rst     in  asynchronous active-low reset
//   d_raw   in  raw data switch, asynchronous to clk
//   s_raw   in  raw step button, asynchronous to clk
//   d       out debounced level of d_raw (registered)
//   s       out one-cycle pulse per debounced rising edge of s_raw (registered)
//   s_count out number of s pulses since reset, wraps without saturation
// -----------------------------------------------------------------------------
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_raw,
    input  logic             s_raw,
    output logic             d,
    output logic             s,
    output logic [CNT_W-1:0] s_count
);

    logic             d_level_s;
    logic             d_flip_s;
    logic             s_level_s;
    logic             s_flip_s;
    logic             s_press_s;
    logic             d_r;
    logic             s_r;
    logic [CNT_W-1:0] s_count_r;

    debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_d_ch (
        .clk   (clk),
        .rst   (rst),
        .raw   (d_raw),
        .level (d_level_s),
        .flip  (d_flip_s)
    );

    debounce_ch #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_s_ch (
        .clk   (clk),
        .rst   (rst),
        .raw   (s_raw),
        .level (s_level_s),
        .flip  (s_flip_s)
    );

    // A press is a flip while the stable value is still low (0 -> 1 only).
    assign s_press_s = s_flip_s & ~s_level_s;

    // Output registers: d loads the channel's next stable value so it moves
    // on the same edge as the debouncer, keeping d aligned with a
    // simultaneous s strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_r <= 1'b0;
            s_r <= 1'b0;
        end else begin
            d_r <= d_level_s ^ d_flip_s;
            s_r <= s_press_s;
        end
    end

    // Strobe event counter, free-running wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_count_r <= {CNT_W{1'b0}};
        end else if (s_press_s) begin
            s_count_r <= s_count_r + CNT_W'(1'b1);
        end else begin
            s_count_r <= s_count_r;
        end
    end

    assign d       = d_r;
    assign s       = s_r;
    assign s_count = s_count_r;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Directed bench for input_conditioner. Two instances share all inputs: one
// with default parameters and one with a 2-bit strobe counter for wrapping.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       d_raw;
    logic       s_raw;
    logic       d;
    logic       s;
    logic [7:0] s_count;
    logic       d_w;
    logic       s_w;
    logic [1:0] s_count_w;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    int wrap_exp [5] = '{1, 2, 3, 0, 1};

    input_conditioner dut (
        .clk     (clk),
        .rst     (rst),
        .d_raw   (d_raw),
        .s_raw   (s_raw),
        .d       (d),
        .s       (s),
        .s_count (s_count)
    );

    input_conditioner #(.CNT_W(2)) dut_w (
        .clk     (clk),
        .rst     (rst),
        .d_raw   (d_raw),
        .s_raw   (s_raw),
        .d       (d_w),
        .s       (s_w),
        .s_count (s_count_w)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic exp_d, input logic exp_s);
        chk({tag, ".d"},       {31'd0, d},         {31'd0, exp_d});
        chk({tag, ".s"},       {31'd0, s},         {31'd0, exp_s});
        chk({tag, ".d_w"},     {31'd0, d_w},       {31'd0, exp_d});
        chk({tag, ".s_w"},     {31'd0, s_w},       {31'd0, exp_s});
        chk({tag, ".cnt"},     {24'd0, s_count},   exp_cnt % 256);
        chk({tag, ".cnt_w"},   {30'd0, s_count_w}, exp_cnt % 4);
    endtask

    // Clean press with d held high: pulse on the 6th edge, nothing on release.
    task automatic press(input string tag);
        s_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 6) exp_cnt++;
            chk_all(tag, 1'b1, (i == 6));
        end
        s_raw = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk_all({tag, "_rel"}, 1'b1, 1'b0);
        end
    endtask

    initial begin
        // Reset held with both raw inputs high.
        rst   = 1'b0;
        d_raw = 1'b1;
        s_raw = 1'b1;
        repeat (3) begin
            step();
            chk_all("reset_hold", 1'b0, 1'b0);
        end

        // Release: high inputs count as a change from 0, full latency.
        rst = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 6) exp_cnt = 1;
            chk_all("release", (i == 6), (i == 6));
        end
        step();
        chk_all("release_after", 1'b1, 1'b0);

        // Debounced release of s gives no pulse.
        s_raw = 1'b0;
        repeat (10) begin
            step();
            chk_all("s_release", 1'b1, 1'b0);
        end

        // Clean press held 20 cycles: exactly one pulse.
        s_raw = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 6) exp_cnt++;
            chk_all("clean_press", 1'b1, (i == 6));
        end
        s_raw = 1'b0;
        repeat (10) begin
            step();
            chk_all("clean_release", 1'b1, 1'b0);
        end

        // 3-cycle glitch on s is rejected.
        s_raw = 1'b1;
        repeat (3) step();
        s_raw = 1'b0;
        repeat (10) begin
            step();
            chk_all("glitch_s", 1'b1, 1'b0);
        end

        // 3-cycle glitch on d is rejected.
        d_raw = 1'b0;
        repeat (3) step();
        d_raw = 1'b1;
        repeat (10) begin
            step();
            chk_all("glitch_d", 1'b1, 1'b0);
        end

        // Bounce: 10 single-cycle toggles, then hold high.
        for (int i = 0; i < 10; i++) begin
            s_raw = ~s_raw;
            step();
            chk_all("bounce", 1'b1, 1'b0);
        end
        s_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 6) exp_cnt++;
            chk_all("bounce_hold", 1'b1, (i == 6));
        end
        s_raw = 1'b0;
        repeat (10) step();
        chk_all("bounce_rel", 1'b1, 1'b0);

        // Simultaneous d and s rise: new d appears with the strobe.
        d_raw = 1'b0;
        repeat (10) step();
        chk_all("simul_pre", 1'b0, 1'b0);
        d_raw = 1'b1;
        s_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 6) exp_cnt++;
            chk_all("simul", (i >= 6), (i == 6));
        end
        s_raw = 1'b0;
        repeat (10) step();

        // Narrow counter wraps 1,2,3,0,1 over five presses.
        for (int p = 0; p < 5; p++) begin
            press("wrap");
            chk("wrap_table", {30'd0, s_count_w}, wrap_exp[p]);
        end

        // Reset two cycles into a press: progress is lost.
        s_raw = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        chk_all("rst_async", 1'b0, 1'b0);
        repeat (2) begin
            step();
            chk_all("rst_mid", 1'b0, 1'b0);
        end
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 6) exp_cnt = 1;
            chk_all("rst_repress", (i >= 6), (i == 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage that feeds the 3-bit FSM (inputs d, s; output q[2:0]).
- Takes raw asynchronous switch/button signals d_raw and s_raw. Synchronises them to clk and debounces each one.
- Presents a clean level d and a single-cycle step strobe s to the FSM.
- Also counts accepted strobes for debug and observation.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per input (min 2).
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from its debounced value before the debounced value flips (min 1).
- CNT_W, 8, width of the strobe event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- d_raw  input  1  raw data switch, asynchronous to clk.
- s_raw  input  1  raw step button, asynchronous to clk.
- d  output  1  debounced level of d_raw, drives FSM d.
- s  output  1  one-cycle pulse on each debounced rising edge of s_raw, drives FSM s.
- s_count  output  CNT_W  number of s pulses issued since reset.

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - all synchroniser flops;
  - both debounced values;
  - both debounce counters;
  - s, d and s_count, all to 0.
- Release is synchronous to the next clk edge. No output changes while rst=0.
- Synchroniser: each raw input passes through SYNC_STAGES flops. The last stage is the synced value.
- Debounce (per channel, identical):
  - State: stable bit plus counter cnt (width clog2(DEBOUNCE_CYCLES)+1).
  - Each edge, if synced == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= synced, cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: a raw change first sampled at edge k, held steady, flips stable at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults that is edge k+5.
- Glitch rejection: a synced deviation lasting fewer than DEBOUNCE_CYCLES edges never changes stable. Its counter returns to 0 when synced matches again.
- d = stable of d channel, registered. Changes on the same edge its stable flips.
- s: registered. s <= 1 on the edge where s-channel stable flips 0->1; s <= 0 on every other edge.
  - Exactly one pulse per debounced press, regardless of hold length.
  - A debounced release (1->0) produces no pulse.
- Simultaneous d and s flips on the same edge:
  - new d and s=1 appear in the same cycle, so the FSM samples the new d with the strobe;
  - d changing one cycle after s is not required to be seen by that strobe.
- s_count increments by 1 on every edge where s is set to 1. Wraps from 2^CNT_W-1 to 0 with no saturation.
- Reset asserted mid-debounce: counters lose progress. After release the input must again be stable for the full latency.
- Raw input already high at reset release: it is treated as a change from 0.
  - d rises after the full latency.
  - s held high through reset produces one pulse after the full latency.

Decomposition:
- Shared package holds:
  - default constants SYNC_STAGES_DEF=2, DEBOUNCE_CYCLES_DEF=4, CNT_W_DEF=8;
  - a helper for the counter width (clog2).
- One natural sub-module, debounce_ch, containing one synchroniser chain plus stable/cnt logic with output level. Instantiated twice, for d and s.
- The top adds the s edge pulse and s_count.

Test Plan:
- Reset: rst=0 with d_raw=1, s_raw=1 for 3 cycles -> d=0, s=0, s_count=0 throughout. Release rst -> d=1 at 6th edge after release; s pulses one cycle at same edge; s_count=1.
- Clean press: d_raw=1 then s_raw 0->1 held 20 cycles -> d=1, a single s pulse 5 edges after s_raw first sampled, s_count +1. Release s_raw -> no pulse.
- Glitch: s_raw high for 3 clk cycles then low -> s never asserts, s_count unchanged. Same for d_raw -> d unchanged.
- Bounce: s_raw toggles every cycle for 10 cycles, then holds 1 -> exactly one s pulse, DEBOUNCE_CYCLES+SYNC_STAGES-1 edges after the final hold begins.
- Simultaneous: d_raw 0->1 and s_raw 0->1 sampled on the same edge -> d and s rise on the same edge; FSM sees d=1 with the strobe.
- Wrap and reset mid-count: with CNT_W=2, 5 presses -> s_count 1,2,3,0,1. Then rst pulsed low while s_raw is 2 cycles into a press -> s_count=0, no pulse until s_raw is re-held for the full latency.
